// File: rtl/hour_set_ctrl_if.sv
// Button inputs and hour-setting outputs of hour_set_ctrl, bundled for port connection.
interface hour_set_ctrl_if;
    logic       btn_mode_i;
    logic       btn_inc_i;
    logic [4:0] ival_o;
    logic       load_o;
    logic       setting_o;
    logic [3:0] segment0_o;
    logic [3:0] segment1_o;

    modport slave (
        input  btn_mode_i, btn_inc_i,
        output ival_o, load_o, setting_o, segment0_o, segment1_o
    );

    modport master (
        output btn_mode_i, btn_inc_i,
        input  ival_o, load_o, setting_o, segment0_o, segment1_o
    );
endinterface

// File: rtl/hour_set_ctrl.sv
// Two-button hour editor: synchronised, debounced mode/inc buttons drive an
// IDLE/SET/COMMIT machine that edits a 0-23 hour and loads it into a counter.
module hour_set_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    hour_set_ctrl_if.slave  bus
);

    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SET    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Index 0 is the mode button, index 1 the increment button.
    logic [1:0] w_btn_raw;
    logic [1:0] w_evt;
    logic       w_mode_evt;
    logic       w_inc_evt;
    logic [7:0] w_bcd;

    state_t     r_state;
    logic [4:0] r_work;
    logic [4:0] r_committed;
    logic [TW-1:0] r_tcnt;
    logic       r_setting;
    logic       r_load;

    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        logic [4:0] n;
        if (h >= 5'd23) begin
            n = 5'd0;
        end else begin
            n = h + 5'd1;
        end
        return n;
    endfunction

    function automatic logic [7:0] hour_to_bcd(input logic [4:0] h);
        logic [3:0] tens;
        logic [4:0] units;
        if (h >= 5'd20) begin
            tens  = 4'd2;
            units = h - 5'd20;
        end else if (h >= 5'd10) begin
            tens  = 4'd1;
            units = h - 5'd10;
        end else begin
            tens  = 4'd0;
            units = h;
        end
        return {tens, units[3:0]};
    endfunction

    assign w_btn_raw  = {bus.btn_inc_i, bus.btn_mode_i};
    assign w_mode_evt = w_evt[0];
    assign w_inc_evt  = w_evt[1];

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic           r_sync0;
        logic           r_sync1;
        logic           r_deb;
        logic           r_deb_d;
        logic           r_evt;
        logic [DBW-1:0] r_dbcnt;

        // Synchronise, debounce and turn each rising debounced level into a one-cycle press pulse
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_sync0 <= 1'b0;
                r_sync1 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_evt   <= 1'b0;
                r_dbcnt <= '0;
            end else begin
                r_sync0 <= w_btn_raw[g];
                r_sync1 <= r_sync0;
                if (r_sync1 != r_deb) begin
                    if (r_dbcnt == DB_LAST) begin
                        r_deb   <= r_sync1;
                        r_dbcnt <= '0;
                    end else begin
                        r_dbcnt <= r_dbcnt + DBW'(1);
                    end
                end else begin
                    r_dbcnt <= '0;
                end
                r_deb_d <= r_deb;
                r_evt   <= r_deb & ~r_deb_d;
            end
        end

        assign w_evt[g] = r_evt;
    end

    // Edit state machine; mode wins over inc, and the timeout restores the committed hour
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_work      <= 5'd0;
            r_committed <= 5'd0;
            r_tcnt      <= '0;
            r_setting   <= 1'b0;
            r_load      <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tcnt <= '0;
                    if (w_mode_evt) begin
                        r_state   <= ST_SET;
                        r_work    <= r_committed;
                        r_setting <= 1'b1;
                    end else begin
                        r_setting <= 1'b0;
                    end
                end
                ST_SET: begin
                    if (w_mode_evt) begin
                        r_committed <= r_work;
                        r_state     <= ST_COMMIT;
                        r_setting   <= 1'b0;
                        r_load      <= 1'b1;
                        r_tcnt      <= '0;
                    end else if (w_inc_evt) begin
                        r_work    <= hour_inc(r_work);
                        r_tcnt    <= '0;
                        r_setting <= 1'b1;
                    end else if (r_tcnt == TO_LAST) begin
                        r_state   <= ST_IDLE;
                        r_work    <= r_committed;
                        r_tcnt    <= '0;
                        r_setting <= 1'b0;
                    end else begin
                        r_tcnt    <= r_tcnt + TW'(1);
                        r_setting <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_state   <= ST_IDLE;
                    r_setting <= 1'b0;
                    r_tcnt    <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_work    <= r_committed;
                    r_setting <= 1'b0;
                    r_tcnt    <= '0;
                end
            endcase
        end
    end

    // Display decode of the working hour
    always_comb begin
        w_bcd = 8'd0;
        w_bcd = hour_to_bcd(r_work);
    end

    assign bus.segment0_o = w_bcd[3:0];
    assign bus.segment1_o = w_bcd[7:4];
    assign bus.ival_o     = r_committed;
    assign bus.load_o     = r_load;
    assign bus.setting_o  = r_setting;

endmodule

// File: tb/tb_hour_set_ctrl.sv
// Scoreboard bench for hour_set_ctrl: a press-level model queues expected
// display/commit events, and a negedge monitor matches what the DUT shows.
module tb_hour_set_ctrl;

    localparam int DEB = 16;
    localparam int TO  = 1024;

    localparam logic [2:0] K_ENTER   = 3'd0;
    localparam logic [2:0] K_INC     = 3'd1;
    localparam logic [2:0] K_COMMIT  = 3'd2;
    localparam logic [2:0] K_ABANDON = 3'd3;
    localparam logic [2:0] K_SPUR    = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] hour;
        logic [4:0] ival;
    } rec_t;

    logic clk;
    logic rstn;
    hour_set_ctrl_if bus ();

    hour_set_ctrl #(.DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TO)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    rec_t exp_q[$];

    // Reference model: edit state seen at the level of whole button presses
    bit m_set    = 1'b0;
    int m_work   = 0;
    int m_commit = 0;

    task automatic push(input logic [2:0] k);
        exp_q.push_back(rec_t'{k, 8'(m_work), 5'(m_commit)});
    endtask

    task automatic hold(input logic m, input logic i, input int n);
        bus.btn_mode_i = m;
        bus.btn_inc_i  = i;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i);
        hold(m, i, DEB + 6 + int'($urandom_range(0, 8)));
        hold(1'b0, 1'b0, DEB + 6 + int'($urandom_range(0, 8)));
    endtask

    task automatic do_mode(input logic with_inc);
        if (!m_set) begin
            m_set  = 1'b1;
            m_work = m_commit;
            push(K_ENTER);
        end else begin
            m_commit = m_work;
            m_set    = 1'b0;
            push(K_COMMIT);
        end
        press(1'b1, with_inc);
    endtask

    task automatic do_inc();
        if (m_set) begin
            m_work = (m_work + 1) % 24;
            push(K_INC);
        end
        press(1'b0, 1'b1);
    endtask

    task automatic do_timeout();
        m_set  = 1'b0;
        m_work = m_commit;
        push(K_ABANDON);
        hold(1'b0, 1'b0, TO + 50);
    endtask

    task automatic check_outs(input string name, input logic [14:0] want);
        logic [14:0] got;
        got = {bus.ival_o, bus.load_o, bus.setting_o, bus.segment1_o, bus.segment0_o};
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, want);
        end
    endtask

    // Monitor: turns visible DUT changes into records and checks them against the queue
    int         mon_cyc   = 0;
    int         last_evt  = 0;
    logic       prev_set  = 1'b0;
    int         prev_hour = 0;
    int         cur_hour;
    bit         got_valid;
    rec_t       got;
    rec_t       want;

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!rstn) begin
                prev_set  = 1'b0;
                prev_hour = 0;
                continue;
            end
            cur_hour  = int'(bus.segment1_o) * 10 + int'(bus.segment0_o);
            got_valid = 1'b0;
            got       = rec_t'{K_SPUR, 8'(cur_hour), bus.ival_o};
            if (bus.load_o) begin
                got.kind  = K_COMMIT;
                got_valid = 1'b1;
            end else if (bus.setting_o && !prev_set) begin
                got.kind  = K_ENTER;
                got_valid = 1'b1;
                last_evt  = mon_cyc;
            end else if (!bus.setting_o && prev_set) begin
                got.kind  = K_ABANDON;
                got_valid = 1'b1;
                n_total++;
                if (mon_cyc - last_evt != TO) begin
                    n_bad++;
                    $display("FAIL timeout_len: got=%0d expected=%0d", mon_cyc - last_evt, TO);
                end
            end else if (cur_hour != prev_hour) begin
                got.kind  = bus.setting_o ? K_INC : K_SPUR;
                got_valid = 1'b1;
                last_evt  = mon_cyc;
            end
            if (got_valid) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got kind=%0d hour=%0d ival=%0d expected none",
                             got.kind, got.hour, got.ival);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL scoreboard: got kind=%0d hour=%0d ival=%0d expected kind=%0d hour=%0d ival=%0d",
                                 got.kind, got.hour, got.ival, want.kind, want.hour, want.ival);
                    end
                end
            end
            prev_set  = bus.setting_o;
            prev_hour = cur_hour;
        end
    end

    initial begin
        int r;
        bus.btn_mode_i = 1'b0;
        bus.btn_inc_i  = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_outs("reset_state", 15'd0);
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // inc while idle is ignored; then 0 -> 5 and commit
        do_inc();
        do_mode(1'b0);
        for (int i = 0; i < 5; i++) do_inc();
        do_mode(1'b0);
        check_outs("commit_5", {5'd5, 1'b0, 1'b0, 4'd0, 4'd5});

        // reach 22, then wrap 23 -> 0 -> 1
        do_mode(1'b0);
        for (int i = 0; i < 17; i++) do_inc();
        do_mode(1'b0);
        do_mode(1'b0);
        for (int i = 0; i < 3; i++) do_inc();
        do_mode(1'b0);
        check_outs("wrap_commit_1", {5'd1, 1'b0, 1'b0, 4'd0, 4'd1});

        // commit 7, then edit to 9 and let it time out
        do_mode(1'b0);
        for (int i = 0; i < 6; i++) do_inc();
        do_mode(1'b0);
        do_mode(1'b0);
        do_inc();
        do_inc();
        do_timeout();
        check_outs("timeout_restore", {5'd7, 1'b0, 1'b0, 4'd0, 4'd7});

        // bouncing inc produces nothing; a clean inc afterwards still counts
        do_mode(1'b0);
        for (int i = 0; i < 12; i++) begin
            hold(1'b0, 1'b1, DEB / 2);
            hold(1'b0, 1'b0, DEB / 2);
        end
        hold(1'b0, 1'b0, DEB / 2);
        check_outs("bounce_unchanged", {5'd7, 1'b0, 1'b1, 4'd0, 4'd7});
        do_inc();
        do_mode(1'b0);

        // simultaneous mode+inc commits the unchanged hour
        do_mode(1'b0);
        do_inc();
        do_mode(1'b1);
        check_outs("both_commit_9", {5'd9, 1'b0, 1'b0, 4'd0, 4'd9});

        // reset mid-edit at hour 15
        do_mode(1'b0);
        for (int i = 0; i < 6; i++) do_inc();
        check_outs("set_at_15", {5'd9, 1'b0, 1'b1, 4'd1, 4'd5});
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_outs("reset_in_set", 15'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        m_set = 1'b0;
        m_work = 0;
        m_commit = 0;
        repeat (60) @(posedge clk);
        #1;
        check_outs("after_reset", 15'd0);

        // randomized press sequences
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 99));
            if (!m_set) begin
                if (r < 70) do_mode(1'b0);
                else        do_inc();
            end else begin
                if (r < 55)      do_inc();
                else if (r < 80) do_mode(1'b0);
                else if (r < 90) do_mode(1'b1);
                else             do_timeout();
            end
        end
        if (m_set) do_mode(1'b0);

        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        check_outs("final_state", {5'(m_commit), 1'b0, 1'b0,
                                   4'(m_commit / 10), 4'(m_commit % 10)});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hour_set_ctrl.md
HOUR_SET_CTRL -- requirements
Module: hour_set_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 16: consecutive stable cycles (>=1) needed to accept a button level change.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024: idle cycles (>=2) in SET before the edit is abandoned.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock; all state on its rising edge.
REQ-004 The block SHALL have port rstn_i, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port btn_mode_i, input, 1 bit: raw asynchronous mode button, active high.
REQ-006 The block SHALL have port btn_inc_i, input, 1 bit: raw asynchronous increment button, active high.
REQ-007 The block SHALL have port ival_o, output, 5 bits: committed hour, binary 0-23; drives the hour counter initial value.
REQ-008 The block SHALL have port load_o, output, 1 bit: one-cycle pulse telling the counter to load ival_o.
REQ-009 The block SHALL have port setting_o, output, 1 bit: high while in SET.
REQ-010 The block SHALL have port segment0_o, output, 4 bits: BCD units digit of the working hour.
REQ-011 The block SHALL have port segment1_o, output, 4 bits: BCD tens digit of the working hour (0-2; bits [3:2] always 0).

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer before any other logic.
REQ-013 Debounce: per button, a counter SHALL increment each cycle the synced level differs from the debounced level and clear to 0 when they match.
REQ-014 The debounced level SHALL flip, and its counter clear, on the DEBOUNCE_CYC-th consecutive mismatch cycle.
REQ-015 A press event SHALL be a registered one-cycle pulse, high in the cycle after the debounced level rises; releases SHALL generate no event.
REQ-016 The FSM SHALL have states IDLE, SET and COMMIT.
REQ-017 IDLE: a mode event SHALL move to SET, with working hour = committed hour; inc events SHALL be ignored.
REQ-018 SET: an inc event SHALL increment the working hour modulo 24 (23 -> 0) on the same edge.
REQ-019 SET: a mode event SHALL copy the working hour to the committed hour and move to COMMIT.
REQ-020 COMMIT SHALL last exactly one cycle, assert load_o for that cycle only, then return to IDLE; events arriving in COMMIT SHALL be dropped.
REQ-021 Mode and inc events in the same cycle SHALL be treated as a mode event only; inc is discarded.
REQ-022 Timeout counter: SHALL clear on entry to SET and on every press event in SET, and increment on every other SET cycle.
REQ-023 Timeout: on the TIMEOUT_CYC-th consecutive event-free SET cycle, the FSM SHALL return to IDLE and restore the working hour to the committed hour; load_o SHALL stay 0.
REQ-024 ival_o SHALL change only on a commit, and SHALL be registered.
REQ-025 setting_o SHALL be registered and high exactly while state is SET.
REQ-026 The segment outputs SHALL decode the working hour combinationally: units = value mod 10; tens = 0 for 0-9, 1 for 10-19, 2 for 20-23.
REQ-027 Hour arithmetic SHALL be 5-bit unsigned; values 24-31 SHALL never be stored.

Reset
REQ-028 While rstn_i is low, all state SHALL clear immediately: synchronizers, debounced levels and counters, events, and timeout counter to 0; FSM to IDLE; working and committed hour to 0.
REQ-029 While rstn_i is low, outputs SHALL be: ival_o=0, load_o=0, setting_o=0, segment0_o=0, segment1_o=0.
REQ-030 Reset asserted during SET or COMMIT SHALL abort the edit, with no load_o pulse.
REQ-031 Reset deassertion SHALL be synchronised to clk_i by the integrating level.

Verification
REQ-032 Mode press held > DEBOUNCE_CYC+3 cycles -> setting_o=1; 5 inc presses, then mode -> segment1_o=0, segment0_o=5, single-cycle load_o, ival_o=5, setting_o=0.
REQ-033 Committed hour 22, enter SET, 3 inc presses -> working hour sequence 23, 0, 1; commit -> ival_o=1.
REQ-034 Bounce: btn_inc_i toggling every DEBOUNCE_CYC/2 cycles for 200 cycles in SET -> no inc event; working hour unchanged.
REQ-035 Committed hour 7, enter SET, 2 incs, no further presses for TIMEOUT_CYC cycles -> IDLE, segment0_o=7, ival_o=7, load_o never high.
REQ-036 Mode and inc debounced on the same cycle in SET -> commit of the unchanged value; working hour not incremented.
REQ-037 rstn_i low for 1 cycle while in SET with working hour 15 -> all outputs 0 immediately; no load_o pulse after release.
